// File: rtl/instr_queue.sv
// instr_queue
// -----------
// Decoupling FIFO between the instruction fetch unit and decode. Each
// fetched {pc, instr} pair is captured together with an exception tag that
// marks PCs which are misaligned or fall outside instruction memory. A
// tagged entry carries a nop (32'h0) in place of its instruction word. A
// redirect (flush) discards every queued entry so no wrong-path instruction
// reaches decode.
//
// Parameters:
//   DEPTH       number of entries (power of two, >= 2)
//   IMEM_BASE   first valid instruction byte address
//   IMEM_WORDS  instruction memory size in 32-bit words
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-low; clears all state
//   in_valid   fetch presents a pair
//   in_ready   queue can accept a pair this cycle (registered state only)
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   flush      redirect; empties the queue, highest priority
//   out_valid  head entry available
//   out_ready  decode consumes the head this cycle
//   out_pc     head PC (0 when out_valid=0)
//   out_instr  head instruction (0 when out_valid=0)
//   out_exc    head PC misaligned or outside instruction memory
//   count      current occupancy
//
// Build option:
//   INSTR_QUEUE_BYPASS_EN  when defined, an incoming pair is presented on
//   out_* in the same cycle while the queue is empty; if decode takes it,
//   it is never stored. When undefined there is no combinational in->out
//   path and the minimum latency is one cycle.

module instr_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // One-past-the-end of instruction memory, kept 33 bits wide so a memory
  // that reaches the top of the address space cannot wrap to a small value.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          exc_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic        in_exc;
  logic [31:0] in_instr_eff;
  logic        stored_valid;
  logic        bypass_active;
  logic        bypass_take;
  logic        push;
  logic        pop;

  assign in_exc = (in_pc[1:0] != 2'b00) ||
                  (in_pc < IMEM_BASE) ||
                  ({1'b0, in_pc} >= IMEM_END);
  assign in_instr_eff = in_exc ? 32'h0 : in_instr;

  assign stored_valid = (count != '0);
  assign in_ready     = (count != FULL_CNT);

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass_active = (count == '0) && in_valid && !flush;
  assign bypass_take   = bypass_active && out_ready;
`else
  assign bypass_active = 1'b0;
  assign bypass_take   = 1'b0;
`endif

  // A bypassed pair that decode consumes immediately must not also be stored.
  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = stored_valid && out_ready && !flush;

  // Head entry takes precedence; the bypass path only drives out_* while
  // nothing is stored. Outputs are forced to zero when nothing is valid.
  always_comb begin
    out_valid = stored_valid || bypass_active;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    out_exc   = 1'b0;
    if (stored_valid) begin
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
      out_exc   = exc_mem[head];
    end else if (bypass_active) begin
      out_pc    = in_pc;
      out_instr = in_instr_eff;
      out_exc   = in_exc;
    end
  end

  // Pointer, occupancy and storage update. Flush wins over push and pop and
  // returns both pointers to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= 32'h0;
        instr_mem[i] <= 32'h0;
        exc_mem[i]   <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= in_pc;
        instr_mem[tail] <= in_instr_eff;
        exc_mem[tail]   <= in_exc;
        tail            <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue
// --------------
// Directed testbench for instr_queue with the default parameters
// (DEPTH=4, IMEM_BASE=0x3000, IMEM_WORDS=4096, so valid PCs are
// 0x3000..0x6FFC). Inputs are driven 1 time unit after a rising edge and
// outputs are observed at that same point, away from the active edge.
// Build option INSTR_QUEUE_BYPASS_EN selects the same-cycle expectations in
// test_bypass.

module tb_instr_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic [2:0]  count;

  int assertions;
  int failures;

  instr_queue #(
    .DEPTH(4),
    .IMEM_BASE(32'h0000_3000),
    .IMEM_WORDS(4096)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_exc(out_exc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_instr  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    assertions++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    assertions++; if (out_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc); end
    step();
    assertions++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: count %0d out_valid %b expected 0/0", count, out_valid); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h3000 + 32'(4 * i);
      in_instr = 32'hA000_0000 + 32'(i);
      step();
      assertions++; if (count !== 3'(i + 1)) begin failures++; $display("[TB] FAIL fill_count_%0d: got %0d expected %0d", i, count, i + 1); end
    end
    assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
    assertions++; if (out_pc !== 32'h3000 || out_instr !== 32'hA000_0000 || out_exc !== 1'b0) begin failures++; $display("[TB] FAIL full_head: got %h/%h/%b expected 00003000/a0000000/0", out_pc, out_instr, out_exc); end
    // Fifth pair is offered while full and must be refused.
    in_pc    = 32'h3010;
    in_instr = 32'hA000_0004;
    step();
    assertions++; if (count !== 3'd4 || out_pc !== 32'h3000) begin failures++; $display("[TB] FAIL fifth_push_refused: count %0d head %h expected 4/00003000", count, out_pc); end
  endtask

  // From full with 0x3010 held on the input: the first cycle only pops
  // (in_ready is 0), the second pushes 0x3010 and pops, then input stops.
  task automatic test_drain_push();
    logic [31:0] exp_pc    [5] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
    logic [2:0]  exp_count [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    logic        exp_rdy   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        drive_in  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = drive_in[i];
      assertions++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin failures++; $display("[TB] FAIL drain_head_%0d: valid %b pc %h expected 1/%h", i, out_valid, out_pc, exp_pc[i]); end
      assertions++; if (in_ready !== exp_rdy[i]) begin failures++; $display("[TB] FAIL drain_in_ready_%0d: got %b expected %b", i, in_ready, exp_rdy[i]); end
      if (i == 4) begin
        assertions++; if (out_instr !== 32'hA000_0004) begin failures++; $display("[TB] FAIL drain_fifth_instr: got %h expected a0000004", out_instr); end
      end
      step();
      assertions++; if (count !== exp_count[i]) begin failures++; $display("[TB] FAIL drain_count_%0d: got %0d expected %0d", i, count, exp_count[i]); end
    end
    in_valid = 1'b0;
    assertions++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("[TB] FAIL drain_empty: valid %b pc %h expected 0/0", out_valid, out_pc); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3018; in_instr = 32'hB000_0000; step();
    in_pc     = 32'h301C; in_instr = 32'hB000_0001; step();
    assertions++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL flush_prefill: got %0d expected 2", count); end
    flush     = 1'b1;
    in_pc     = 32'h3020; in_instr = 32'hB000_0002;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    assertions++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_clear: count %0d valid %b ready %b expected 0/0/1", count, out_valid, in_ready); end
    step();
    assertions++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("[TB] FAIL flush_dropped_push: valid %b pc %h expected 0/0", out_valid, out_pc); end
    // Pointers restart cleanly after the flush.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h3024; in_instr = 32'hB000_0003;
    step();
    in_valid  = 1'b0;
    assertions++; if (count !== 3'd1 || out_pc !== 32'h3024 || out_instr !== 32'hB000_0003) begin failures++; $display("[TB] FAIL flush_restart: count %0d pc %h instr %h expected 1/00003024/b0000003", count, out_pc, out_instr); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_exception();
    logic [31:0] pcs [6] = '{32'h2FFC, 32'h3002, 32'h7000, 32'h6FFC, 32'h3000, 32'hFFFF_FFFC};
    logic        exc [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_instr;
      exp_instr = exc[i] ? 32'h0 : (32'hC000_0000 + 32'(i));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = pcs[i];
      in_instr  = 32'hC000_0000 + 32'(i);
      step();
      in_valid  = 1'b0;
      assertions++; if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_exc !== exc[i] || out_instr !== exp_instr) begin failures++; $display("[TB] FAIL exc_%h: valid %b exc %b instr %h expected 1/%b/%h", pcs[i], out_valid, out_exc, out_instr, exc[i], exp_instr); end
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    assertions++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL exc_drained: got %0d expected 0", count); end
  endtask

  task automatic test_bypass();
    in_valid  = 1'b1;
    in_pc     = 32'h3040;
    in_instr  = 32'hD000_0000;
    out_ready = 1'b1;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    assertions++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 || out_instr !== 32'hD000_0000) begin failures++; $display("[TB] FAIL bypass_same_cycle: valid %b pc %h instr %h expected 1/00003040/d0000000", out_valid, out_pc, out_instr); end
    step();
    in_valid = 1'b0;
    assertions++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bypass_not_stored: count %0d valid %b expected 0/0", count, out_valid); end
`else
    assertions++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("[TB] FAIL no_bypass_same_cycle: valid %b pc %h expected 0/0", out_valid, out_pc); end
    step();
    in_valid = 1'b0;
    assertions++; if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h3040) begin failures++; $display("[TB] FAIL no_bypass_next_cycle: count %0d valid %b pc %h expected 1/1/00003040", count, out_valid, out_pc); end
    step();
    assertions++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL no_bypass_pop: got %0d expected 0", count); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3050; in_instr = 32'hE000_0000; step();
    in_pc     = 32'h3054; in_instr = 32'hE000_0001; step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    assertions++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("[TB] FAIL async_reset: count %0d valid %b pc %h expected 0/0/0", count, out_valid, out_pc); end
    step();
    reset = 1'b1;
    step();
    assertions++; if (count !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL after_async_reset: count %0d ready %b expected 0/1", count, in_ready); end
    out_ready = 1'b0;
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    test_reset();
    test_fill();
    test_drain_push();
    test_flush();
    test_exception();
    test_bypass();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
